// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT CBC sequencer.
package present_pkg;

  localparam int BLK_W       = 64;
  localparam int KEY_W       = 80;
  localparam int TIMEOUT_DEF = 64;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BLK,
    S_LOAD,
    S_RUN,
    S_OUT,
    S_ERR
  } state_e;

endpackage

// File: rtl/present_cbc_chain.sv
// CBC chain register with the pre-encrypt and post-decrypt XOR paths.
module present_cbc_chain
  import present_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             iv_ld,
  input  logic [BLK_W-1:0] iv,
  input  logic             upd,
  input  logic [BLK_W-1:0] blk_in,
  input  logic [BLK_W-1:0] inblk,
  input  logic [BLK_W-1:0] core_odat,
  output logic [BLK_W-1:0] chain,
  output logic [BLK_W-1:0] pre_xor,
  output logic [BLK_W-1:0] post_xor
);

  logic [BLK_W-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (iv_ld)
      chain_d = iv;
    else if (upd)
      chain_d = (mode == MODE_ENC) ? core_odat : inblk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign chain    = chain_q;
  assign pre_xor  = (mode == MODE_ENC) ? (blk_in ^ chain_q) : blk_in;
  assign post_xor = (mode == MODE_ENC) ? core_odat : (core_odat ^ chain_q);

endmodule

// File: rtl/present_cbc_ctrl.sv
// CBC-mode message sequencer for the PRESENT core: one load per block,
// done/timeout supervision and a valid/ready result stream.
module present_cbc_ctrl
  import present_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             iReset_n,
  input  logic             iStart,
  input  logic             iMode,
  input  logic [KEY_W-1:0] iKey,
  input  logic [BLK_W-1:0] iIv,
  input  logic [BLK_W-1:0] iBlk,
  input  logic             iBlkValid,
  input  logic             iBlkLast,
  output logic             oBlkReady,
  output logic [BLK_W-1:0] oOut,
  output logic             oOutValid,
  output logic             oOutLast,
  input  logic             iOutReady,
  output logic             oBusy,
  output logic             oErr,
  output logic             core_load,
  output logic             core_control,
  output logic [BLK_W-1:0] core_idat,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_done,
  input  logic [BLK_W-1:0] core_odat
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             ctrl_q, ctrl_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] idat_q, idat_d;
  logic [BLK_W-1:0] inblk_q, inblk_d;
  logic             last_q, last_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             ovld_q, ovld_d;
  logic             olast_q, olast_d;
  logic             err_q, err_d;
  logic             iv_ld, chain_upd;
  logic [BLK_W-1:0] chain, pre_xor, post_xor;

  present_cbc_chain u_chain (
    .clk       (clk),
    .rst_n     (iReset_n),
    .mode      (ctrl_q),
    .iv_ld     (iv_ld),
    .iv        (iIv),
    .upd       (chain_upd),
    .blk_in    (iBlk),
    .inblk     (inblk_q),
    .core_odat (core_odat),
    .chain     (chain),
    .pre_xor   (pre_xor),
    .post_xor  (post_xor)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = 1'b0;
    ctrl_d    = ctrl_q;
    key_d     = key_q;
    idat_d    = idat_q;
    inblk_d   = inblk_q;
    last_d    = last_q;
    out_d     = out_q;
    ovld_d    = ovld_q;
    olast_d   = olast_q;
    err_d     = err_q;
    iv_ld     = 1'b0;
    chain_upd = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: if (iStart) begin
        ctrl_d  = iMode;
        key_d   = iKey;
        iv_ld   = 1'b1;
        err_d   = 1'b0;
        state_d = S_WAIT_BLK;
      end
      S_WAIT_BLK: if (iBlkValid) begin
        inblk_d = iBlk;
        last_d  = iBlkLast;
        idat_d  = pre_xor;
        load_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      // Counter runs from the load cycle, so it equals cycles since load.
      S_LOAD: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_done && cnt_q >= CNT_W'(2)) begin
          out_d     = post_xor;
          chain_upd = 1'b1;
          ovld_d    = 1'b1;
          olast_d   = last_q;
          state_d   = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_OUT: if (iOutReady) begin
        ovld_d  = 1'b0;
        olast_d = 1'b0;
        state_d = last_q ? S_IDLE : S_WAIT_BLK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      ctrl_q  <= 1'b0;
      key_q   <= '0;
      idat_q  <= '0;
      inblk_q <= '0;
      last_q  <= 1'b0;
      out_q   <= '0;
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
      key_q   <= key_d;
      idat_q  <= idat_d;
      inblk_q <= inblk_d;
      last_q  <= last_d;
      out_q   <= out_d;
      ovld_q  <= ovld_d;
      olast_q <= olast_d;
      err_q   <= err_d;
    end
  end

  assign oBlkReady    = (state_q == S_WAIT_BLK);
  assign oBusy        = (state_q != S_IDLE);
  assign oOut         = out_q;
  assign oOutValid    = ovld_q;
  assign oOutLast     = olast_q;
  assign oErr         = err_q;
  assign core_load    = load_q;
  assign core_control = ctrl_q;
  assign core_idat    = idat_q;
  assign core_key     = key_q;

endmodule

// File: tb/tb_present_cbc_ctrl.sv
// Directed bench for present_cbc_ctrl with a behavioural PRESENT-80 core model.
module tb_present_cbc_ctrl;

  logic        clk = 1'b0;
  logic        iReset_n;
  logic        iStart, iMode, iBlkValid, iBlkLast, iOutReady;
  logic [79:0] iKey;
  logic [63:0] iIv, iBlk;
  logic        oBlkReady, oOutValid, oOutLast, oBusy, oErr;
  logic [63:0] oOut;
  logic        core_load, core_control, core_done;
  logic [63:0] core_idat, core_odat;
  logic [79:0] core_key;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int loads = 0;
  int load_cyc = 0;
  logic [63:0] last_idat = '0;
  bit ovalid_seen = 0;
  bit done_en = 1;

  localparam logic [63:0] CT0 = 64'h5579C1387B228445;
  localparam logic [63:0] CT1 = 64'hE72C46C0F5945049;
  localparam int CORE_LAT = 31;

  present_cbc_ctrl dut (
    .clk(clk), .iReset_n(iReset_n), .iStart(iStart), .iMode(iMode), .iKey(iKey),
    .iIv(iIv), .iBlk(iBlk), .iBlkValid(iBlkValid), .iBlkLast(iBlkLast),
    .oBlkReady(oBlkReady), .oOut(oOut), .oOutValid(oOutValid), .oOutLast(oOutLast),
    .iOutReady(iOutReady), .oBusy(oBusy), .oErr(oErr), .core_load(core_load),
    .core_control(core_control), .core_idat(core_idat), .core_key(core_key),
    .core_done(core_done), .core_odat(core_odat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sb_inv(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hA970364BD21C8FE5;
    return t[{x, 2'b00} +: 4];
  endfunction

  function automatic int pmap(input int i);
    return (i == 63) ? 63 : (i * 16) % 63;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input int r);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = sb(n[79:76]);
    n[19:15] = n[19:15] ^ 5'(r);
    return n;
  endfunction

  function automatic logic [63:0] present_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key; s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb(s[n*4 +: 4]);
      t = '0;
      for (int i = 0; i < 64; i++) t[pmap(i)] = s[i];
      s = t;
      k = key_upd(k, r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] present_dec(input logic [79:0] key, input logic [63:0] ct);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      rk[r] = k[79:16];
      k = key_upd(k, r);
    end
    rk[32] = k[79:16];
    s = ct ^ rk[32];
    for (int r = 31; r >= 1; r--) begin
      t = '0;
      for (int i = 0; i < 64; i++) t[i] = s[pmap(i)];
      s = t;
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb_inv(s[n*4 +: 4]);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  // Core model: result CORE_LAT cycles after load, done held until next load.
  int          core_cnt = 0;
  bit          core_busy = 0;
  logic [63:0] core_res = '0;
  initial begin core_done = 1'b0; core_odat = '0; end

  always @(posedge clk) begin
    if (core_load) begin
      core_done <= 1'b0;
      core_busy <= 1'b1;
      core_cnt  <= CORE_LAT;
      core_res  <= core_control ? present_dec(core_key, core_idat)
                                : present_enc(core_key, core_idat);
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy <= 1'b0;
        core_odat <= core_res;
        if (done_en) core_done <= 1'b1;
      end else core_cnt <= core_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (core_load) begin
      loads     = loads + 1;
      load_cyc  = cyc;
      last_idat = core_idat;
    end
    if (oOutValid) ovalid_seen = 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_msg(input logic mode, input logic [79:0] key, input logic [63:0] iv);
    iStart = 1'b1; iMode = mode; iKey = key; iIv = iv;
    @(negedge clk);
    iStart = 1'b0;
  endtask

  task automatic send_blk(input logic [63:0] blk, input logic last);
    int n;
    iBlk = blk; iBlkLast = last; iBlkValid = 1'b1;
    n = 0;
    while (!oBlkReady && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("blk_ready_tmo", 0, 1);
    @(negedge clk);
    iBlkValid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!oOutValid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("out_valid_tmo", 0, 1);
  endtask

  task automatic run_blk(input string tag, input logic [63:0] blk, input logic last,
                         input logic [63:0] exp);
    send_blk(blk, last);
    wait_out();
    check(tag, oOut, exp);
    check({tag, "_last"}, oOutLast, last);
    iOutReady = 1'b1;
    @(negedge clk);
    iOutReady = 1'b0;
  endtask

  logic [63:0] c1, c2, held;
  int l0, n;
  bit stable;

  initial begin
    iReset_n = 1'b0; iStart = 0; iMode = 0; iKey = '0; iIv = '0;
    iBlk = '0; iBlkValid = 0; iBlkLast = 0; iOutReady = 0;
    repeat (3) @(negedge clk);
    check("rst_outs", {oOutValid, oOutLast, oBusy, oErr, core_load, core_control, oBlkReady}, 0);
    check("rst_key", core_key, 0);
    check("rst_data", {core_idat, oOut}, 0);
    iReset_n = 1'b1;
    @(negedge clk);

    // single-block encrypt, zero key
    l0 = loads;
    start_msg(1'b0, 80'h0, 64'h0);
    run_blk("enc_zero", 64'h0, 1'b1, CT0);
    check("enc_zero_loads", loads - l0, 1);
    check("enc_zero_idle", oBusy, 0);

    // all-ones key
    start_msg(1'b0, {80{1'b1}}, 64'h0);
    run_blk("enc_ones", 64'h0, 1'b1, CT1);

    // two-block CBC chain
    start_msg(1'b0, 80'h0, 64'h0);
    run_blk("cbc_b0", 64'h0, 1'b0, CT0);
    check("cbc_b0_busy", oBusy, 1);
    c1 = CT0;
    c2 = present_enc(80'h0, CT0);
    run_blk("cbc_b1", 64'h0, 1'b1, c2);
    check("cbc_b1_idat", last_idat, c1);

    // decrypt round trip
    start_msg(1'b1, 80'h0, 64'h0);
    run_blk("dec_b0", c1, 1'b0, 64'h0);
    check("dec_chain", dut.u_chain.chain_q, c1);
    run_blk("dec_b1", c2, 1'b1, 64'h0);

    // timeout
    done_en = 0;
    start_msg(1'b0, 80'h0, 64'h0);
    ovalid_seen = 0;
    send_blk(64'h0, 1'b1);
    n = 0;
    while (!oErr && n < 200) begin @(negedge clk); n++; end
    check("tmo_lat", cyc - load_cyc, 64);
    check("tmo_no_out", ovalid_seen, 0);
    check("tmo_busy", oBusy, 1);
    done_en = 1;
    start_msg(1'b0, 80'h0, 64'h0);
    check("tmo_clear", {oErr, oBusy}, 2'b01);
    run_blk("tmo_recover", 64'h0, 1'b1, CT0);

    // backpressure
    start_msg(1'b0, 80'h0, 64'h0);
    send_blk(64'h0, 1'b1);
    wait_out();
    held = oOut;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!oOutValid || oOut !== held) stable = 0;
    end
    check("bp_stable", stable, 1);
    check("bp_value", held, CT0);
    iOutReady = 1'b1;
    @(negedge clk);
    iOutReady = 1'b0;

    // reset during RUN
    start_msg(1'b0, {80{1'b1}}, 64'h0123456789ABCDEF);
    l0 = loads;
    iBlk = 64'h0; iBlkLast = 1'b1; iBlkValid = 1'b1;
    n = 0;
    while (loads == l0 && n < 100) begin @(negedge clk); n++; end
    iBlkValid = 1'b0;
    repeat (4) @(negedge clk);
    iReset_n = 1'b0;
    #1;
    check("arst_outs", {oOutValid, oOutLast, oBusy, oErr, core_load, core_control}, 0);
    check("arst_key", core_key, 0);
    check("arst_data", {core_idat, oOut}, 0);
    @(negedge clk);
    iReset_n = 1'b1;
    ovalid_seen = 0;
    repeat (80) @(negedge clk);
    check("arst_no_out", ovalid_seen, 0);
    check("arst_idle", oBusy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
